// File: rtl/md_unit_if.sv
// Pipeline-side bundle for the multiply/divide unit: E-stage issue, D-stage use, HI/LO and stall.
// Unit has no backpressure on issue; the pipeline honours stall_D instead.
interface md_unit_if;
  logic        start_E;
  logic [2:0]  md_op_E;
  logic [31:0] src_a_E;
  logic [31:0] src_b_E;
  logic        md_use_D;
  logic        busy;
  logic        stall_D;
  logic [31:0] md_out_E;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start_E, md_op_E, src_a_E, src_b_E, md_use_D,
    input  busy, stall_D, md_out_E, hi, lo
  );

  modport slave (
    input  start_E, md_op_E, src_a_E, src_b_E, md_use_D,
    output busy, stall_D, md_out_E, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// Multiply/divide unit owning HI/LO; MULT* busy MULT_CYCLES, DIV* busy DIV_CYCLES, MT*/MF* single-cycle.
// Issue while busy is ignored; stall_D holds D-stage MD ops while a mul/div starts or runs.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic      clk,
  input logic      reset,
  md_unit_if.slave md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MFHI  = 3'd6;
  localparam logic [2:0] OP_MFLO  = 3'd7;

  typedef enum logic {IDLE, RUN} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    res_hi_q, res_hi_d;
  logic [31:0]    res_lo_q, res_lo_d;
  logic [31:0]    hi_q, hi_d;
  logic [31:0]    lo_q, lo_d;

  logic [63:0]    smul, umul, result;
  logic [31:0]    abs_a, abs_b, dvd, dvs, uq, ur, sq, sr;

  // Signed divide runs on magnitudes through the same divider as DIVU; the
  // 0x80000000 / -1 case falls out naturally as 0x80000000 rem 0.
  always_comb begin
    smul   = 64'($signed({{32{md.src_a_E[31]}}, md.src_a_E}) *
                 $signed({{32{md.src_b_E[31]}}, md.src_b_E}));
    umul   = {32'd0, md.src_a_E} * {32'd0, md.src_b_E};
    abs_a  = md.src_a_E[31] ? (32'd0 - md.src_a_E) : md.src_a_E;
    abs_b  = md.src_b_E[31] ? (32'd0 - md.src_b_E) : md.src_b_E;
    dvd    = (md.md_op_E == OP_DIV) ? abs_a : md.src_a_E;
    dvs    = (md.md_op_E == OP_DIV) ? abs_b : md.src_b_E;
    if (dvs == 32'd0) begin
      dvs = 32'd1;
    end
    uq     = dvd / dvs;
    ur     = dvd % dvs;
    sq     = (md.src_a_E[31] ^ md.src_b_E[31]) ? (32'd0 - uq) : uq;
    sr     = md.src_a_E[31] ? (32'd0 - ur) : ur;
    result = 64'd0;
    case (md.md_op_E)
      OP_MULT:  result = smul;
      OP_MULTU: result = umul;
      OP_DIV:   result = (md.src_b_E == 32'd0) ? {md.src_a_E, 32'hFFFF_FFFF} : {sr, sq};
      OP_DIVU:  result = (md.src_b_E == 32'd0) ? {md.src_a_E, 32'hFFFF_FFFF} : {ur, uq};
      default:  result = 64'd0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (md.start_E) begin
          case (md.md_op_E)
            OP_MULT, OP_MULTU: begin
              res_hi_d = result[63:32];
              res_lo_d = result[31:0];
              cnt_d    = CW'(MULT_CYCLES);
              state_d  = RUN;
            end
            OP_DIV, OP_DIVU: begin
              res_hi_d = result[63:32];
              res_lo_d = result[31:0];
              cnt_d    = CW'(DIV_CYCLES);
              state_d  = RUN;
            end
            OP_MTHI: hi_d = md.src_a_E;
            OP_MTLO: lo_d = md.src_a_E;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q == CW'(1)) begin
          hi_d    = res_hi_q;
          lo_d    = res_lo_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign md.busy     = (state_q == RUN);
  assign md.stall_D  = md.md_use_D & (md.busy | (md.start_E & ~md.md_op_E[2]));
  assign md.md_out_E = (md.md_op_E == OP_MFHI) ? hi_q :
                       (md.md_op_E == OP_MFLO) ? lo_q : 32'd0;
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: arithmetic results, busy length, stall window, MT/MF, async reset.
module tb_md_unit;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;
  int   n;
  logic busy_seen_hl;

  md_unit_if mif ();

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    mif.start_E = 1'b1;
    mif.md_op_E = op;
    mif.src_a_E = a;
    mif.src_b_E = b;
    tick();
    mif.start_E = 1'b0;
    #1;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (mif.busy && cycles < 50) begin
      cycles++;
      tick();
    end
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset = 1'b1;
    mif.start_E = 1'b0;
    mif.md_op_E = 3'd0;
    mif.src_a_E = 32'd0;
    mif.src_b_E = 32'd0;
    mif.md_use_D = 1'b0;
    #22;
    chk("reset_busy", {31'd0, mif.busy}, 32'd0);
    chk("reset_hi", mif.hi, 32'd0);
    chk("reset_lo", mif.lo, 32'd0);
    reset = 1'b0;
    tick();

    // MULT -3 * 7; HI/LO must hold their old values while busy
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7);
    n = 0;
    busy_seen_hl = 1'b0;
    while (mif.busy && n < 50) begin
      if (mif.hi !== 32'd0 || mif.lo !== 32'd0) busy_seen_hl = 1'b1;
      n++;
      tick();
    end
    chk("mult_busy_cycles", n, 32'd5);
    chk("mult_hilo_hidden", {31'd0, busy_seen_hl}, 32'd0);
    chk("mult_hi", mif.hi, 32'hFFFF_FFFF);
    chk("mult_lo", mif.lo, 32'hFFFF_FFEB);

    // idle with D-stage MD op and no start: no stall
    mif.md_use_D = 1'b1;
    mif.md_op_E = 3'd0;
    #1;
    chk("idle_no_stall", {31'd0, mif.stall_D}, 32'd0);
    chk("mfout_non_mf", mif.md_out_E, 32'd0);

    // DIVU 100/7 with D-stage MD op held: stall from start until busy falls
    mif.start_E = 1'b1;
    mif.md_op_E = 3'd3;
    mif.src_a_E = 32'd100;
    mif.src_b_E = 32'd7;
    #1;
    n = 0;
    do begin
      n++;
      tick();
      mif.start_E = 1'b0;
      #1;
    end while (mif.stall_D && n < 50);
    chk("divu_stall_cycles", n, 32'd11);
    chk("divu_hi", mif.hi, 32'd2);
    chk("divu_lo", mif.lo, 32'd14);
    mif.md_op_E = 3'd7;
    #1;
    chk("mflo_out", mif.md_out_E, 32'd14);
    mif.md_use_D = 1'b0;

    // signed divide cases
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    chk("div_neg_cycles", n, 32'd10);
    chk("div_neg_lo", mif.lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", mif.hi, 32'hFFFF_FFFF);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("div_ovf_lo", mif.lo, 32'h8000_0000);
    chk("div_ovf_hi", mif.hi, 32'd0);
    run_op(3'd2, 32'd5, 32'd0);
    wait_idle(n);
    chk("div0_cycles", n, 32'd10);
    chk("div0_lo", mif.lo, 32'hFFFF_FFFF);
    chk("div0_hi", mif.hi, 32'd5);
    run_op(3'd3, 32'd9, 32'd0);
    wait_idle(n);
    chk("divu0_lo", mif.lo, 32'hFFFF_FFFF);
    chk("divu0_hi", mif.hi, 32'd9);

    // MTHI then MFHI next cycle
    run_op(3'd4, 32'h0000_1234, 32'd0);
    chk("mthi_no_busy", {31'd0, mif.busy}, 32'd0);
    mif.start_E = 1'b1;
    mif.md_op_E = 3'd6;
    #1;
    chk("mfhi_out", mif.md_out_E, 32'h0000_1234);
    tick();
    mif.start_E = 1'b0;

    // MTLO while busy is ignored and does not disturb the counter
    run_op(3'd1, 32'd4, 32'd5);
    tick();
    run_op(3'd5, 32'hDEAD_BEEF, 32'd0);
    wait_idle(n);
    chk("mtlo_busy_remaining", n, 32'd3);
    chk("mtlo_busy_lo", mif.lo, 32'd20);
    chk("mtlo_busy_hi", mif.hi, 32'd0);

    // async reset at counter==3 of a DIV
    run_op(3'd2, 32'd100, 32'd3);
    for (int i = 0; i < 7; i++) tick();
    chk("pre_reset_busy", {31'd0, mif.busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", {31'd0, mif.busy}, 32'd0);
    chk("arst_hi", mif.hi, 32'd0);
    chk("arst_lo", mif.lo, 32'd0);
    #2;
    reset = 1'b0;
    tick();
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    chk("multu_cycles", n, 32'd5);
    chk("multu_hi", mif.hi, 32'd1);
    chk("multu_lo", mif.lo, 32'hFFFF_FFFE);

    // back-to-back: DIVU issued in the first idle cycle
    run_op(3'd1, 32'd2, 32'd3);
    wait_idle(n);
    chk("b2b_mul_lo", mif.lo, 32'd6);
    chk("b2b_mul_hi", mif.hi, 32'd0);
    run_op(3'd3, 32'd9, 32'd4);
    chk("b2b_div_busy", {31'd0, mif.busy}, 32'd1);
    wait_idle(n);
    chk("b2b_div_cycles", n, 32'd10);
    chk("b2b_div_hi", mif.hi, 32'd1);
    chk("b2b_div_lo", mif.lo, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
